// File: rtl/posit_stream_checker.sv
// -----------------------------------------------------------------------------
// posit_stream_checker
//
// On-chip self-check engine for a posit arithmetic unit. A run walks NUM_VEC
// operand pairs out of three synchronous-read memories (in1, in2, expected)
// that share one address. Each operand pair is registered into the DUT. The
// DUT result is compared against the expected word, which is delayed to line
// up with it. The comparison uses the unsigned bit-pattern distance.
// Mismatch count, largest distance and first failing index are accumulated.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle run request, honoured in IDLE or DONE only
//   busy                high while vectors are being issued or drained
//   done                level, high from run completion until the next start
//   vec_addr            shared read address of the three stimulus memories
//   in1_mem, in2_mem    operand memory data, valid one cycle after vec_addr
//   exp_mem             golden memory data, valid one cycle after vec_addr
//   dut_in1, dut_in2    registered DUT operands (hold between runs)
//   dut_out             DUT result, DUT_LAT cycles after dut_in1/dut_in2
//   err_count           number of vectors whose distance exceeds TOL
//   max_diff            largest distance seen in the run
//   first_fail_idx      index of the first failing vector
//   first_fail_vld      first_fail_idx has been captured
//   pass                done with zero errors
//
// Configuration macro
//   POSIT_CHK_NAR_EN    when defined, an expected NaR (1 followed by zeros)
//                       passes only on an exact NaR result and never updates
//                       max_diff; when undefined NaR is an ordinary pattern.
// -----------------------------------------------------------------------------
module posit_stream_checker #(
    parameter int N       = 8,
    parameter int ES      = 4,
    parameter int ADDR_W  = 16,
    parameter int NUM_VEC = 65536,
    parameter int DUT_LAT = 0,
    parameter int TOL     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [N-1:0]      in1_mem,
    input  logic [N-1:0]      in2_mem,
    input  logic [N-1:0]      exp_mem,
    output logic [N-1:0]      dut_in1,
    output logic [N-1:0]      dut_in2,
    input  logic [N-1:0]      dut_out,
    output logic [ADDR_W:0]   err_count,
    output logic [N-1:0]      max_diff,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              first_fail_vld,
    output logic              pass
);

    // ES only matters to the DUT wrapper; it is used here for the sanity check.
    if (N < 3 || ES < 0 || NUM_VEC < 1 || NUM_VEC > (2 ** ADDR_W) || DUT_LAT < 0)
    begin : g_bad_cfg
        $error("posit_stream_checker: illegal parameter combination");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
    localparam logic [N-1:0]      TOL_V    = N'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    // Unsigned distance between two bit patterns.
    function automatic logic [N-1:0] bit_dist(input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic accept;
    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    // ---- Stage p0: memory data cycle (one cycle after vec_addr) -------------
    logic              vld_p0;
    logic [ADDR_W-1:0] idx_p0;

    // ---- Stage pl[0..DUT_LAT]: operands at DUT input, then DUT latency ------
    logic [DUT_LAT:0]  vld_pl;
    logic [ADDR_W-1:0] idx_pl [DUT_LAT+1];
    logic [N-1:0]      exp_pl [DUT_LAT+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_pl <= '0;
        end else begin
            vld_p0    <= (state == ST_ISSUE);
            vld_pl[0] <= vld_p0;
            for (int i = 1; i <= DUT_LAT; i++) begin
                vld_pl[i] <= vld_pl[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_p0    <= vec_addr;
        idx_pl[0] <= idx_p0;
        exp_pl[0] <= exp_mem;
        for (int i = 1; i <= DUT_LAT; i++) begin
            idx_pl[i] <= idx_pl[i-1];
            exp_pl[i] <= exp_pl[i-1];
        end
    end

    // Operands are only loaded from valid memory data so they hold between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in1 <= '0;
            dut_in2 <= '0;
        end else if (vld_p0) begin
            dut_in1 <= in1_mem;
            dut_in2 <= in2_mem;
        end
    end

    // ---- Compare stage: exp_pl[DUT_LAT] aligned with dut_out ----------------
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_idx;
    logic [N-1:0]      cmp_exp;
    logic [N-1:0]      cmp_diff;
    logic              cmp_fail;
    logic              cmp_upd_max;

    assign cmp_vld  = vld_pl[DUT_LAT];
    assign cmp_idx  = idx_pl[DUT_LAT];
    assign cmp_exp  = exp_pl[DUT_LAT];
    assign cmp_diff = bit_dist(cmp_exp, dut_out);

`ifdef POSIT_CHK_NAR_EN
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
    logic cmp_is_nar;
    assign cmp_is_nar  = (cmp_exp == NAR);
    assign cmp_fail    = cmp_is_nar ? (dut_out != NAR) : (cmp_diff > TOL_V);
    assign cmp_upd_max = !cmp_is_nar && (cmp_diff > max_diff);
`else
    assign cmp_fail    = (cmp_diff > TOL_V);
    assign cmp_upd_max = (cmp_diff > max_diff);
`endif

    // ---- Control FSM ---------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: if (vec_addr == LAST_IDX) state_nxt = ST_DRAIN;
            // The last vector is in its compare cycle: its results land on
            // the same edge that enters DONE.
            ST_DRAIN: if (cmp_vld && cmp_idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_ISSUE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    // ---- Address counter and result accumulators ----------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_addr       <= '0;
            err_count      <= '0;
            max_diff       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else if (accept) begin
            vec_addr       <= '0;
            err_count      <= '0;
            max_diff       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            if (state == ST_ISSUE && vec_addr != LAST_IDX) begin
                vec_addr <= vec_addr + ADDR_W'(1);
            end
            if (cmp_vld) begin
                if (cmp_upd_max) begin
                    max_diff <= cmp_diff;
                end
                if (cmp_fail) begin
                    err_count <= err_count + (ADDR_W+1)'(1);
                    if (!first_fail_vld) begin
                        first_fail_idx <= cmp_idx;
                        first_fail_vld <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_posit_stream_checker
//
// Directed bench for posit_stream_checker. Three checker instances (N=8,
// NUM_VEC=4) run against behavioural memories sharing one set of tables:
//   u0: DUT_LAT=0, TOL=0     u3: DUT_LAT=3, TOL=0     u1: DUT_LAT=0, TOL=1
// The stand-in DUT computes dut_in1 ^ dut_in2 (pipelined three deep for u3),
// so each table row stores in1 = wanted_out ^ in2.
// -----------------------------------------------------------------------------
module tb_posit_stream_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tab [4];
    logic [7:0] in1_tab [4];
    logic [7:0] in2_tab [4];

    // ---------------- instance u0 : latency 0, TOL 0 ----------------
    logic       busy0, done0, pass0, ffv0;
    logic [7:0] va0, ffi0, i1m0, i2m0, em0, di1_0, di2_0, do0, max0;
    logic [8:0] err0;
    always @(posedge clk) begin
        i1m0 <= in1_tab[va0[1:0]];
        i2m0 <= in2_tab[va0[1:0]];
        em0  <= exp_tab[va0[1:0]];
    end
    assign do0 = di1_0 ^ di2_0;

    posit_stream_checker #(.N(8), .ES(4), .ADDR_W(8), .NUM_VEC(4), .DUT_LAT(0), .TOL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy0), .done(done0),
        .vec_addr(va0), .in1_mem(i1m0), .in2_mem(i2m0), .exp_mem(em0),
        .dut_in1(di1_0), .dut_in2(di2_0), .dut_out(do0), .err_count(err0),
        .max_diff(max0), .first_fail_idx(ffi0), .first_fail_vld(ffv0), .pass(pass0));

    // ---------------- instance u3 : latency 3, TOL 0 ----------------
    logic       busy3, done3, pass3, ffv3;
    logic [7:0] va3, ffi3, i1m3, i2m3, em3, di1_3, di2_3, do3, max3;
    logic [7:0] p3a, p3b, p3c;
    logic [8:0] err3;
    always @(posedge clk) begin
        i1m3 <= in1_tab[va3[1:0]];
        i2m3 <= in2_tab[va3[1:0]];
        em3  <= exp_tab[va3[1:0]];
        p3a  <= di1_3 ^ di2_3;
        p3b  <= p3a;
        p3c  <= p3b;
    end
    assign do3 = p3c;

    posit_stream_checker #(.N(8), .ES(4), .ADDR_W(8), .NUM_VEC(4), .DUT_LAT(3), .TOL(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy3), .done(done3),
        .vec_addr(va3), .in1_mem(i1m3), .in2_mem(i2m3), .exp_mem(em3),
        .dut_in1(di1_3), .dut_in2(di2_3), .dut_out(do3), .err_count(err3),
        .max_diff(max3), .first_fail_idx(ffi3), .first_fail_vld(ffv3), .pass(pass3));

    // ---------------- instance u1 : latency 0, TOL 1 ----------------
    logic       busy1, done1, pass1, ffv1;
    logic [7:0] va1, ffi1, i1m1, i2m1, em1, di1_1, di2_1, do1, max1;
    logic [8:0] err1;
    always @(posedge clk) begin
        i1m1 <= in1_tab[va1[1:0]];
        i2m1 <= in2_tab[va1[1:0]];
        em1  <= exp_tab[va1[1:0]];
    end
    assign do1 = di1_1 ^ di2_1;

    posit_stream_checker #(.N(8), .ES(4), .ADDR_W(8), .NUM_VEC(4), .DUT_LAT(0), .TOL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy1), .done(done1),
        .vec_addr(va1), .in1_mem(i1m1), .in2_mem(i2m1), .exp_mem(em1),
        .dut_in1(di1_1), .dut_in2(di2_1), .dut_out(do1), .err_count(err1),
        .max_diff(max1), .first_fail_idx(ffi1), .first_fail_vld(ffv1), .pass(pass1));

    // Row k: expected word e, wanted DUT output o.
    task automatic set_vec(input int k, input logic [7:0] e, input logic [7:0] o);
        in2_tab[k] = 8'h3C ^ 8'(k);
        in1_tab[k] = o ^ in2_tab[k];
        exp_tab[k] = e;
    endtask

    // Start high during cycle 0; returns at the falling edge inside cycle 1.
    task automatic pulse_start(input int which);
        @(negedge clk);
        start_v[which] = 1'b1;
        @(negedge clk);
        start_v[which] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start_v = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset.busy got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset.done got %b want 0", done0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset.pass got %b want 0", pass0); end
        checks++; if (va0 !== 8'd0) begin errors++; $display("FAIL reset.vec_addr got %h want 00", va0); end
        checks++; if (di1_0 !== 8'd0 || di2_0 !== 8'd0) begin errors++; $display("FAIL reset.dut_in got %h/%h want 00/00", di1_0, di2_0); end
        checks++; if (err0 !== 9'd0 || max0 !== 8'd0) begin errors++; $display("FAIL reset.counters got err=%0d max=%h want 0/00", err0, max0); end
        checks++; if (ffi0 !== 8'd0 || ffv0 !== 1'b0) begin errors++; $display("FAIL reset.first_fail got %h/%b want 00/0", ffi0, ffv0); end
        checks++; if (done3 !== 1'b0 || done1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset.others got done3=%b done1=%b busy3=%b want 0", done3, done1, busy3); end
    endtask

    task automatic test_exact;
        set_vec(0, 8'h10, 8'h10); set_vec(1, 8'h22, 8'h22);
        set_vec(2, 8'h40, 8'h40); set_vec(3, 8'h7E, 8'h7E);
        pulse_start(0);                       // now in cycle 1
        checks++; if (busy0 !== 1'b1 || va0 !== 8'd0) begin errors++; $display("FAIL exact.c1 got busy=%b addr=%h want 1/00", busy0, va0); end
        @(negedge clk);                       // cycle 2
        checks++; if (va0 !== 8'd1) begin errors++; $display("FAIL exact.c2_addr got %h want 01", va0); end
        repeat (4) @(negedge clk);            // cycle 6
        checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL exact.c6 got done=%b busy=%b want 0/1", done0, busy0); end
        @(negedge clk);                       // cycle 7
        checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL exact.c7 got done=%b busy=%b want 1/0", done0, busy0); end
        checks++; if (err0 !== 9'd0 || max0 !== 8'd0) begin errors++; $display("FAIL exact.result got err=%0d max=%h want 0/00", err0, max0); end
        checks++; if (pass0 !== 1'b1 || ffv0 !== 1'b0) begin errors++; $display("FAIL exact.pass got pass=%b ffv=%b want 1/0", pass0, ffv0); end
        checks++; if (di1_0 !== (8'h7E ^ 8'h3F) || di2_0 !== 8'h3F) begin errors++; $display("FAIL exact.dut_in got %h/%h want %h/3f", di1_0, di2_0, 8'h7E ^ 8'h3F); end
    endtask

    // Starts from DONE of the previous run.
    task automatic test_one_error;
        set_vec(2, 8'h40, 8'h45);
        pulse_start(0);                       // cycle 1
        checks++; if (done0 !== 1'b0 || pass0 !== 1'b0) begin errors++; $display("FAIL rerun.c1 got done=%b pass=%b want 0/0", done0, pass0); end
        repeat (6) @(negedge clk);            // cycle 7
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL one_err.done got %b want 1", done0); end
        checks++; if (err0 !== 9'd1 || max0 !== 8'h05) begin errors++; $display("FAIL one_err.result got err=%0d max=%h want 1/05", err0, max0); end
        checks++; if (ffi0 !== 8'd2 || ffv0 !== 1'b1 || pass0 !== 1'b0) begin errors++; $display("FAIL one_err.ff got idx=%h vld=%b pass=%b want 02/1/0", ffi0, ffv0, pass0); end
    endtask

    task automatic test_latency;
        set_vec(0, 8'h10, 8'h10); set_vec(1, 8'h22, 8'h24);
        set_vec(2, 8'h40, 8'h40); set_vec(3, 8'h00, 8'h7F);
        pulse_start(1);                       // cycle 1
        repeat (8) @(negedge clk);            // cycle 9
        checks++; if (done3 !== 1'b0 || busy3 !== 1'b1) begin errors++; $display("FAIL lat3.c9 got done=%b busy=%b want 0/1", done3, busy3); end
        @(negedge clk);                       // cycle 10
        checks++; if (done3 !== 1'b1 || busy3 !== 1'b0) begin errors++; $display("FAIL lat3.c10 got done=%b busy=%b want 1/0", done3, busy3); end
        checks++; if (err3 !== 9'd2 || max3 !== 8'h7F) begin errors++; $display("FAIL lat3.result got err=%0d max=%h want 2/7f", err3, max3); end
        checks++; if (ffi3 !== 8'd1 || ffv3 !== 1'b1 || pass3 !== 1'b0) begin errors++; $display("FAIL lat3.ff got idx=%h vld=%b pass=%b want 01/1/0", ffi3, ffv3, pass3); end
    endtask

    task automatic test_tolerance;
        set_vec(0, 8'h10, 8'h11); set_vec(1, 8'h22, 8'h21);
        set_vec(2, 8'h40, 8'h41); set_vec(3, 8'h00, 8'h01);
        pulse_start(2);                       // cycle 1
        repeat (6) @(negedge clk);            // cycle 7
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL tol.done got %b want 1", done1); end
        checks++; if (err1 !== 9'd0 || max1 !== 8'h01) begin errors++; $display("FAIL tol.result got err=%0d max=%h want 0/01", err1, max1); end
        checks++; if (pass1 !== 1'b1 || ffv1 !== 1'b0) begin errors++; $display("FAIL tol.pass got pass=%b ffv=%b want 1/0", pass1, ffv1); end
    endtask

    task automatic test_nar;
        logic [7:0] want_max;
`ifdef POSIT_CHK_NAR_EN
        want_max = 8'h00;
`else
        want_max = 8'h01;
`endif
        set_vec(0, 8'h80, 8'h7F); set_vec(1, 8'h10, 8'h10);
        set_vec(2, 8'h10, 8'h10); set_vec(3, 8'h10, 8'h10);
        pulse_start(0);                       // cycle 1
        repeat (6) @(negedge clk);            // cycle 7
        checks++; if (err0 !== 9'd1 || ffi0 !== 8'd0 || ffv0 !== 1'b1) begin errors++; $display("FAIL nar.err got err=%0d idx=%h vld=%b want 1/00/1", err0, ffi0, ffv0); end
        checks++; if (max0 !== want_max) begin errors++; $display("FAIL nar.max got %h want %h", max0, want_max); end
    endtask

    task automatic test_reset_midrun;
        set_vec(0, 8'h10, 8'h10); set_vec(1, 8'h22, 8'h22);
        set_vec(2, 8'h40, 8'h45); set_vec(3, 8'h7E, 8'h7E);
        pulse_start(0);                       // cycle 1
        @(negedge clk);                       // cycle 2
        rst_n = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || va0 !== 8'd0) begin errors++; $display("FAIL midrst.ctrl got busy=%b done=%b addr=%h want 0/0/00", busy0, done0, va0); end
        checks++; if (di1_0 !== 8'd0 || di2_0 !== 8'd0) begin errors++; $display("FAIL midrst.dut_in got %h/%h want 00/00", di1_0, di2_0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || err0 !== 9'd0 || ffv0 !== 1'b0) begin errors++; $display("FAIL midrst.idle got busy=%b err=%0d ffv=%b want 0/0/0", busy0, err0, ffv0); end

        pulse_start(0);                       // cycle 1
        repeat (2) @(negedge clk);            // cycle 3: start while busy
        start_v[0] = 1'b1;
        @(negedge clk);                       // cycle 4
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);            // cycle 6
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL ignore.c6 got done=%b want 0", done0); end
        @(negedge clk);                       // cycle 7
        checks++; if (done0 !== 1'b1 || err0 !== 9'd1 || max0 !== 8'h05) begin errors++; $display("FAIL ignore.c7 got done=%b err=%0d max=%h want 1/1/05", done0, err0, max0); end
        checks++; if (ffi0 !== 8'd2 || pass0 !== 1'b0) begin errors++; $display("FAIL ignore.ff got idx=%h pass=%b want 02/0", ffi0, pass0); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) set_vec(k, 8'h00, 8'h00);
        test_reset;
        test_exact;
        test_one_error;
        test_latency;
        test_tolerance;
        test_nar;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
